// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit.
//   funct3 codes for RISC-V loads/stores, FSM state encoding and a
//   request-legality helper used when a request is accepted.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // True when the request must be rejected: unknown funct3, unsigned store, or misaligned H/W.
  function automatic logic req_is_bad(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic illegal;
    logic misaligned;
    illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) ||
                 ((f3 == F3_W) && (lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering between a 32-bit memory word and the CPU.
//   addr_lo    in  2   byte offset within the word
//   funct3     in  3   load/store width and signedness
//   rdata      in  32  word read from memory
//   wdata      in  16  low half of store data (all SB/SH need)
//   load_ext_c out 32  extracted and sign/zero-extended load value
//   merge_c    out 32  rdata with the addressed byte/halfword replaced (SB/SH)
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_ext_c,
  output logic [31:0] merge_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, little-endian: byte 0 is bits [7:0].
  always_comb begin
    byte_sel = rdata[7:0];
    half_sel = rdata[15:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    if (addr_lo[1]) half_sel = rdata[31:16];
  end

  // Load extension.
  always_comb begin
    load_ext_c = rdata;
    case (funct3)
      F3_B:    load_ext_c = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_ext_c = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_ext_c = {24'd0, byte_sel};
      F3_HU:   load_ext_c = {16'd0, half_sel};
      default: load_ext_c = rdata;
    endcase
  end

  // Store merge for the read-modify-write path.
  always_comb begin
    merge_c = rdata;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0: merge_c[7:0]   = wdata[7:0];
          2'd1: merge_c[15:8]  = wdata[7:0];
          2'd2: merge_c[23:16] = wdata[7:0];
          2'd3: merge_c[31:24] = wdata[7:0];
          default: merge_c = rdata;
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) merge_c[31:16] = wdata;
        else            merge_c[15:0]  = wdata;
      end
      default: merge_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for a word-wide data BRAM. Turns one load/store request
// into BRAM cycles, extends loads, read-modify-writes SB/SH, flags bad requests.
//   clk, rst                 clock, synchronous active-high reset
//   req/req_we/req_funct3    request strobe (taken when not busy), store flag, funct3
//   req_addr/req_wdata       byte address, store data
//   busy/done/err            in progress, one-cycle completion, error with done
//   load_data                extended load result, held until the next done
//   mem_addr/mem_write_en/mem_wdata/mem_rdata   BRAM port (word index)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned RD_LAT = 1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic        mem_write_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  rd_cnt;
  logic              lat_we;
  logic [2:0]        lat_f3;
  logic [1:0]        lat_lo;
  logic [15:0]       lat_wdata;
  logic              ready_c;
  logic              accept_c;
  logic              req_bad_c;
  logic [31:0]       load_ext_c;
  logic [31:0]       merge_c;
  logic              unused_addr_hi;

  // Address bits above the memory window are intentionally ignored.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // DONE/ERR count as idle so a new request is taken in the completion cycle.
  assign ready_c   = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign accept_c  = req && ready_c;
  assign req_bad_c = req_is_bad(req_we, req_funct3, req_addr[1:0]);

  mem_lane_align u_align (
    .addr_lo    (lat_lo),
    .funct3     (lat_f3),
    .rdata      (mem_rdata),
    .wdata      (lat_wdata),
    .load_ext_c (load_ext_c),
    .merge_c    (merge_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        state_next = S_IDLE;
        if (req) begin
          if (req_bad_c)                           state_next = S_ERR;
          else if (req_we && req_funct3 == F3_W)   state_next = S_WR;
          else                                     state_next = S_RD;
        end
      end
      S_RD:    if (rd_cnt == CNT_LAST) state_next = S_CAP;
      S_CAP:   state_next = lat_we ? S_WR : S_DONE;
      S_WR:    state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register; write enable also masked by reset.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      S_RD, S_CAP: busy = 1'b1;
      S_WR: begin
        busy         = 1'b1;
        mem_write_en = !rst;
      end
      S_DONE, S_ERR: done = 1'b1;
      default: ;
    endcase
  end

  // Request latch, read-latency counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= '0;
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_lo    <= 2'd0;
      lat_wdata <= 16'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      load_data <= 32'd0;
      err       <= 1'b0;
    end else begin
      if (accept_c) begin
        lat_we    <= req_we;
        lat_f3    <= req_funct3;
        lat_lo    <= req_addr[1:0];
        lat_wdata <= req_wdata[15:0];
        mem_addr  <= 32'(req_addr[ADDR_W+1:2]);
        rd_cnt    <= '0;
        if (state_next == S_WR) mem_wdata <= req_wdata;
      end
      if (state == S_RD) rd_cnt <= rd_cnt + CNT_W'(1);
      if (state == S_CAP) begin
        if (lat_we) mem_wdata <= merge_c;
        else        load_data <= load_ext_c;
      end
      if (state_next == S_ERR)       err <= 1'b1;
      else if (state_next == S_DONE) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int LAT = 1;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst, req, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        busy, done, err, mem_write_en;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

  mem_access_unit #(.ADDR_W(20), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- BRAM environment ----------------
  logic [31:0] bram [256];
  logic [31:0] rd_pipe [LAT];
  logic        mem_init;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
    end else if (mem_write_en) begin
      bram[mem_addr[7:0]] <= mem_wdata;
    end
    rd_pipe[0] <= bram[mem_addr[7:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // ---------------- checking bookkeeping ----------------
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- transaction-level reference model ----------------
  logic [31:0] ref_mem [256];
  bit          active, rst_prev, t_err, t_isload;
  int          t_start, t_done, t_wr;
  logic [31:0] t_idx, t_load, t_wdata;
  logic [31:0] held_load, held_addr;
  logic        held_err;
  logic        exp_busy, exp_done, exp_we;
  logic [31:0] exp_wdata;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] v;
    int sh;
    v = w;
    if (f3 == F3_B || f3 == F3_BU) begin
      sh = 8 * int'(lo);
      v = (w >> sh) & 32'hFF;
      if (f3 == F3_B && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3 == F3_H || f3 == F3_HU) begin
      sh = 16 * int'(lo[1]);
      v = (w >> sh) & 32'hFFFF;
      if (f3 == F3_H && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] mask;
    int sh;
    if (f3 == F3_B) begin
      sh = 8 * int'(lo);
      mask = 32'hFF << sh;
      return (old & ~mask) | ((wd & 32'hFF) << sh);
    end else if (f3 == F3_H) begin
      sh = 16 * int'(lo[1]);
      mask = 32'hFFFF << sh;
      return (old & ~mask) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  function automatic bit model_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit legal_code;
    legal_code = we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                    : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    if (!legal_code) return 1;
    if ((f3 == F3_H || f3 == F3_HU) && (a % 2 != 0)) return 1;
    if (f3 == F3_W && (a % 4 != 0)) return 1;
    return 0;
  endfunction

  // Expected outputs for the current cycle given this cycle's inputs.
  task automatic model_cycle(input logic r, input logic q, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
    bit bad;
    int lat;
    logic [31:0] old;
    if (rst_prev) begin
      active = 0; held_load = 0; held_err = 0; held_addr = 0;
    end
    if (active && cyc == t_start) held_addr = t_idx;
    exp_done  = active && (cyc == t_done);
    exp_busy  = active && (cyc < t_done);
    exp_we    = active && (cyc == t_wr) && !r;
    exp_wdata = t_wdata;
    if (exp_done) begin
      held_err = t_err;
      if (t_isload) held_load = t_load;
    end
    if (exp_we) ref_mem[t_idx[7:0]] = t_wdata;
    if (exp_done) active = 0;
    if (q && !exp_busy && !r) begin
      bad = model_bad(we, f3, a);
      lat = bad ? 1 : (!we ? LAT + 2 : (f3 == F3_W ? 2 : LAT + 3));
      t_idx    = (a >> 2) & 32'h000F_FFFF;
      old      = ref_mem[t_idx[7:0]];
      t_start  = cyc + 1;
      t_done   = cyc + lat;
      t_wr     = (!bad && we) ? cyc + lat - 1 : -1;
      t_err    = bad;
      t_isload = !bad && !we;
      t_load   = model_load(old, f3, a[1:0]);
      t_wdata  = model_store(old, wd, f3, a[1:0]);
      active   = 1;
    end
    rst_prev = r;
  endtask

  task automatic step(input logic r, input logic q, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    rst = r; req = q; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    model_cycle(r, q, we, f3, a, wd);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  // ---------------- per-cycle compare against the model ----------------
  int          wr_cnt = 0;
  logic [31:0] last_wr;
  int          done_q [$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("mem_write_en", {31'd0, mem_write_en}, {31'd0, exp_we});
      chk("err", {31'd0, err}, {31'd0, held_err});
      chk("load_data", load_data, held_load);
      chk("mem_addr", mem_addr, held_addr);
      if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      if (mem_write_en === 1'b1) begin
        wr_cnt++;
        last_wr = mem_wdata;
      end
      if (done === 1'b1) done_q.push_back(cyc);
    end
  end

  // ---------------- directed transaction with literal expectations ----------------
  task automatic run_txn(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int exp_lat, input logic exp_err,
                         input bit chk_val, input logic [31:0] exp_val);
    int k;
    int seen;
    k = cyc;
    seen = -1;
    step(1'b0, 1'b1, we, f3, a, wd);
    for (int i = 0; i < 12 && seen < 0; i++) begin
      if (done === 1'b1) seen = cyc;
      else idle();
    end
    if (seen < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 12 cycles (cycle %0d)", nm, cyc);
    end else begin
      chk({nm, "_latency"}, 32'(seen - k), 32'(exp_lat));
      chk({nm, "_err"}, {31'd0, err}, {31'd0, exp_err});
      if (chk_val) chk({nm, "_value"}, load_data, exp_val);
    end
    idle();
  endtask

  logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    int k, w0, base, diffs;
    logic [31:0] a, wd;
    logic [2:0]  f3;
    logic        we, q, r;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    active = 0; rst_prev = 1; held_load = 0; held_err = 0; held_addr = 0;
    t_start = 0; t_done = 0; t_wr = -1; t_idx = 0; t_load = 0; t_wdata = 0; t_err = 0; t_isload = 0;
    last_wr = 0;

    mem_init = 1'b1;
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    mem_init = 1'b0;
    chk_en = 1;
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    // Reset values.
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_we", {31'd0, mem_write_en}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    idle();

    // Word store then load.
    run_txn("sw_8", 1'b1, F3_W, 32'h8, 32'h8899AABB, 2, 1'b0, 0, 32'd0);
    run_txn("lw_8", 1'b0, F3_W, 32'h8, 32'd0, 3, 1'b0, 1, 32'h8899AABB);
    chk("lw_8_mem_addr", mem_addr, 32'd2);

    // Byte/halfword loads on 0xC3FF2211.
    run_txn("sw_4", 1'b1, F3_W, 32'h4, 32'hC3FF2211, 2, 1'b0, 0, 32'd0);
    run_txn("lb_6", 1'b0, F3_B, 32'h6, 32'd0, 3, 1'b0, 1, 32'hFFFFFFFF);
    run_txn("lbu_6", 1'b0, F3_BU, 32'h6, 32'd0, 3, 1'b0, 1, 32'h000000FF);
    run_txn("lh_6", 1'b0, F3_H, 32'h6, 32'd0, 3, 1'b0, 1, 32'hFFFFC3FF);
    run_txn("lhu_4", 1'b0, F3_HU, 32'h4, 32'd0, 3, 1'b0, 1, 32'h00002211);

    // Byte store read-modify-write.
    run_txn("sw_4b", 1'b1, F3_W, 32'h4, 32'h11223344, 2, 1'b0, 0, 32'd0);
    w0 = wr_cnt;
    run_txn("sb_5", 1'b1, F3_B, 32'h5, 32'h000000AB, 4, 1'b0, 0, 32'd0);
    chk("sb_5_writes", 32'(wr_cnt - w0), 32'd1);
    chk("sb_5_wdata", last_wr, 32'h1122AB44);
    run_txn("lw_4", 1'b0, F3_W, 32'h4, 32'd0, 3, 1'b0, 1, 32'h1122AB44);

    // Misaligned and illegal requests: error done next cycle, no write.
    w0 = wr_cnt;
    run_txn("sh_3", 1'b1, F3_H, 32'h3, 32'hFFFF, 1, 1'b1, 1, 32'h1122AB44);
    run_txn("f3_011", 1'b0, 3'b011, 32'h0, 32'd0, 1, 1'b1, 0, 32'd0);
    chk("err_writes", 32'(wr_cnt - w0), 32'd0);
    run_txn("lw_clear_err", 1'b0, F3_W, 32'h8, 32'd0, 3, 1'b0, 1, 32'h8899AABB);

    // Reset while a word store sits in its write cycle.
    w0 = wr_cnt;
    step(1'b0, 1'b1, 1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    chk("rstwr_in_wr", {31'd0, mem_write_en}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    chk("rstwr_busy", {31'd0, busy}, 32'd0);
    chk("rstwr_done", {31'd0, done}, 32'd0);
    chk("rstwr_writes", 32'(wr_cnt - w0), 32'd0);
    idle();

    // Back-to-back loads with req held high.
    k = cyc;
    base = done_q.size();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, F3_W, 32'h8, 32'd0);
    idle();
    idle();
    if (done_q.size() < base + 2) begin
      n_chk++;
      n_fail++;
      $display("FAIL b2b_dones: actual=%0d required=2 (cycle %0d)", done_q.size() - base, cyc);
    end else begin
      chk("b2b_first_done", 32'(done_q[base] - k), 32'd3);
      chk("b2b_second_done", 32'(done_q[base + 1] - k), 32'd6);
    end

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      q  = ($urandom_range(0, 1) == 1);
      we = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else                          f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      a[21:10] = 12'd0;
      case ($urandom_range(0, 3))
        0: a[1:0] = 2'b00;
        1: a[0] = 1'b0;
        default: ;
      endcase
      wd = $urandom;
      step(r, q, we, f3, a, wd);
    end
    for (int i = 0; i < 8; i++) idle();

    // Final memory image must match the model's.
    diffs = 0;
    for (int i = 0; i < 256; i++) if (bram[i] !== ref_mem[i]) diffs++;
    chk("mem_image_diffs", 32'(diffs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
